capture_pi_controller: RTL and testbench
========================================

Name: capture_pi_controller

Overview:
- Consumes each measurement from the input-capture stage (capture value, valid strobe, overflow flag) and runs one discrete PI update per sample.
- Produces an unsigned duty word for the downstream PWM stage.
- Sits between input_capture and the PWM generator to close the SMPS loop.
- Multi-cycle sequential datapath using one shared multiplier.

Parameters:
CAP_LEN, 9, width of capture value and setpoint
GAIN_LEN, 8, width of unsigned kp/ki gains
SHIFT, 6, right-shift applied to the PI sum (gain 1.0 = 2^SHIFT)
DUTY_LEN, 8, width of duty output
DUTY_MAX, 255, upper duty clamp (must be < 2^DUTY_LEN)
ACC_LEN, 20, integrator width, signed

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
capture  in  CAP_LEN  measured value from input_capture
capture_valid  in  1  one-cycle strobe; capture/overflow valid this cycle
overflow  in  1  measurement overflowed (qualified by capture_valid)
setpoint  in  CAP_LEN  target capture value, unsigned
kp  in  GAIN_LEN  proportional gain, unsigned
ki  in  GAIN_LEN  integral gain, unsigned
fault_clr  in  1  clears fault
duty  out  DUTY_LEN  registered duty command
duty_valid  out  1  one-cycle pulse when duty updates
busy  out  1  high in any state other than IDLE
fault  out  1  sticky overflow fault
missed  out  1  one-cycle pulse when capture_valid is dropped

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, duty=0, duty_valid=0, busy=0, fault=0, missed=0, integrator acc=0. Reset aborts any update in progress; no duty_valid is emitted.
- FSM states: IDLE -> ERR -> PMUL -> IMUL -> OUT -> IDLE.
- IDLE: on capture_valid, latch capture, setpoint, kp, ki, overflow.
  - overflow=1: go to OUT with forced result (duty 0, acc cleared, fault set).
  - Otherwise go to ERR.
- ERR: err = setpoint - capture, signed, CAP_LEN+1 bits, no saturation needed.
- PMUL: p = err * kp, signed, CAP_LEN+GAIN_LEN+1 bits.
- IMUL:
  - acc_next = acc + err*ki, clamped to [0, DUTY_MAX<<SHIFT]; this is the anti-windup rule.
  - sum = p + acc_next; u = sum >>> SHIFT (arithmetic, floor).
- OUT:
  - duty = clamp(u, 0, DUTY_MAX); acc = acc_next; duty_valid=1 for exactly this cycle; return to IDLE.
  - The multiplier is shared between PMUL and IMUL.
- Latency: capture_valid sampled at edge N -> duty and duty_valid change at edge N+4 (duty_valid visible cycle N+4 to N+5). Throughput is one sample per 5 cycles.
- capture_valid while busy: sample dropped, missed pulses high one cycle, state and datapath unaffected.
- Overflow sample: duty=0, acc=0, fault=1 at OUT, duty_valid pulses.
- While fault=1:
  - Further non-overflow samples are processed normally; fault stays set.
  - fault_clr clears it the next edge.
  - If fault_clr coincides with an overflow OUT, set wins.
- Inputs setpoint/kp/ki may change at any time; only the values latched at IDLE are used.
- duty holds its value between updates.

Decomposition:
- Shared include (capture_pi_defs.vh): FSM state encodings (3-bit), default SHIFT, DUTY_MAX.
- One natural sub-module: sat_clamp (signed value -> clamp to [lo, hi], parameterised widths), instantiated for the accumulator and duty clamps.
- Multiplier inferred inline.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-update (valid at N, reset at N+2) -> duty=0, no duty_valid, busy=0, acc=0 afterwards.
- Proportional only: setpoint=100, capture=90, kp=64, ki=0, valid at N -> duty=10, duty_valid high exactly at edge N+4. Then capture=110 -> duty=0 (clamped low).
- Integral: kp=0, ki=64, setpoint=100, capture=90, three samples 10 cycles apart -> duty 10, 20, 30. Then capture=110 (err -10) -> duty 20.
- Saturation/anti-windup: setpoint=511, capture=0, kp=255, ki=255, 5 samples -> duty=255 each, acc=16320. One sample err=-1 with kp=0, ki=64 -> duty=254 (no windup recovery delay).
- Overflow: valid with overflow=1 -> duty=0, fault=1, duty_valid pulse. Normal sample -> fault still 1. fault_clr pulse -> fault=0 next edge.
- Back-to-back: valid at N and N+2 -> missed pulses at N+2, single duty_valid at N+4 reflecting the first sample only.

Source files
------------

// File: rtl/capture_pi_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : capture_pi_controller_pkg
// Brief    : Shared state encoding and default loop constants for the
//            capture-driven PI duty controller.
// Revision : 1.0 - initial release
// ============================================================================
package capture_pi_controller_pkg;

  // Controller sequencing: one PI update walks IDLE -> ERR -> PMUL -> IMUL -> OUT
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_PMUL = 3'd2,
    ST_IMUL = 3'd3,
    ST_OUT  = 3'd4
  } pi_state_t;

  // Gain of 1.0 is 2^SHIFT; duty saturates at DUTY_MAX
  localparam int C_DEFAULT_SHIFT    = 6;
  localparam int C_DEFAULT_DUTY_MAX = 255;

endpackage
`default_nettype wire

// File: rtl/capture_pi_controller_sat_clamp.sv
`default_nettype none
// ============================================================================
// Module   : capture_pi_controller_sat_clamp
// Brief    : Clamps a signed value into the constant window [LO, HI] and
//            returns the low OUT_LEN bits of the clamped result.
// Revision : 1.0 - initial release
// ============================================================================
module capture_pi_controller_sat_clamp #(
  parameter int IN_LEN  = 21,
  parameter int OUT_LEN = 20,
  parameter int LO      = 0,
  parameter int HI      = 255
) (
  input  logic signed [IN_LEN-1:0]  i_value,
  output logic        [OUT_LEN-1:0] o_result
);

  localparam logic signed [IN_LEN-1:0] C_LO     = IN_LEN'(LO);
  localparam logic signed [IN_LEN-1:0] C_HI     = IN_LEN'(HI);
  localparam logic        [OUT_LEN-1:0] C_LO_OUT = C_LO[OUT_LEN-1:0];
  localparam logic        [OUT_LEN-1:0] C_HI_OUT = C_HI[OUT_LEN-1:0];

  // Pass the value through unless it falls outside the window
  always_comb begin
    o_result = i_value[OUT_LEN-1:0];
    if (i_value < C_LO) begin
      o_result = C_LO_OUT;
    end else if (i_value > C_HI) begin
      o_result = C_HI_OUT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/capture_pi_controller.sv
`default_nettype none
// ============================================================================
// Module   : capture_pi_controller
// Brief    : Discrete PI regulator between input capture and PWM. Each
//            accepted capture runs one multi-cycle update through a single
//            shared multiplier and produces a clamped unsigned duty word.
// Revision : 1.0 - initial release
// ============================================================================
module capture_pi_controller
  import capture_pi_controller_pkg::*;
#(
  parameter int CAP_LEN  = 9,
  parameter int GAIN_LEN = 8,
  parameter int SHIFT    = C_DEFAULT_SHIFT,
  parameter int DUTY_LEN = 8,
  parameter int DUTY_MAX = C_DEFAULT_DUTY_MAX,
  parameter int ACC_LEN  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CAP_LEN-1:0]  capture,
  input  logic                capture_valid,
  input  logic                overflow,
  input  logic [CAP_LEN-1:0]  setpoint,
  input  logic [GAIN_LEN-1:0] kp,
  input  logic [GAIN_LEN-1:0] ki,
  input  logic                fault_clr,
  output logic [DUTY_LEN-1:0] duty,
  output logic                duty_valid,
  output logic                busy,
  output logic                fault,
  output logic                missed
);

  localparam int C_ERR_LEN  = CAP_LEN + 1;
  localparam int C_PROD_LEN = CAP_LEN + GAIN_LEN + 1;
  localparam int C_SUM_LEN  = ACC_LEN + 1;
  localparam int C_ACC_HI   = DUTY_MAX << SHIFT;

  pi_state_t r_state;
  pi_state_t w_next_state;

  logic [CAP_LEN-1:0]          r_capture;
  logic [CAP_LEN-1:0]          r_setpoint;
  logic [GAIN_LEN-1:0]         r_kp;
  logic [GAIN_LEN-1:0]         r_ki;
  logic                        r_overflow;
  logic signed [C_ERR_LEN-1:0] r_err;
  logic signed [C_PROD_LEN-1:0] r_p;
  logic signed [ACC_LEN-1:0]   r_acc;
  logic signed [ACC_LEN-1:0]   r_acc_next;
  logic signed [C_SUM_LEN-1:0] r_u;

  logic [GAIN_LEN-1:0]          w_gain;
  logic signed [C_PROD_LEN-1:0] w_prod;
  logic signed [C_SUM_LEN-1:0]  w_acc_sum;
  logic [ACC_LEN-1:0]           w_acc_clamped;
  logic signed [C_SUM_LEN-1:0]  w_sum;
  logic signed [C_SUM_LEN-1:0]  w_u;
  logic [DUTY_LEN-1:0]          w_duty_clamped;

  assign busy = (r_state != ST_IDLE);

  // Single multiplier: kp in PMUL, ki in IMUL
  assign w_gain = (r_state == ST_IMUL) ? r_ki : r_kp;
  assign w_prod = C_PROD_LEN'(r_err) * C_PROD_LEN'($signed({1'b0, w_gain}));

  // Integrator candidate, then anti-windup clamp to [0, DUTY_MAX << SHIFT]
  assign w_acc_sum = C_SUM_LEN'(r_acc) + C_SUM_LEN'(w_prod);

  capture_pi_controller_sat_clamp #(
    .IN_LEN  (C_SUM_LEN),
    .OUT_LEN (ACC_LEN),
    .LO      (0),
    .HI      (C_ACC_HI)
  ) u_acc_clamp (
    .i_value  (w_acc_sum),
    .o_result (w_acc_clamped)
  );

  // PI sum uses the already-clamped integrator so saturation recovers at once
  assign w_sum = C_SUM_LEN'(r_p) + C_SUM_LEN'($signed(w_acc_clamped));
  assign w_u   = w_sum >>> SHIFT;

  capture_pi_controller_sat_clamp #(
    .IN_LEN  (C_SUM_LEN),
    .OUT_LEN (DUTY_LEN),
    .LO      (0),
    .HI      (DUTY_MAX)
  ) u_duty_clamp (
    .i_value  (r_u),
    .o_result (w_duty_clamped)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state sequencing; an overflow sample skips straight to the output step
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (capture_valid) w_next_state = overflow ? ST_OUT : ST_ERR;
      ST_ERR:  w_next_state = ST_PMUL;
      ST_PMUL: w_next_state = ST_IMUL;
      ST_IMUL: w_next_state = ST_OUT;
      ST_OUT:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: latch operands, step the PI arithmetic, publish duty in OUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_capture  <= '0;
      r_setpoint <= '0;
      r_kp       <= '0;
      r_ki       <= '0;
      r_overflow <= 1'b0;
      r_err      <= '0;
      r_p        <= '0;
      r_acc      <= '0;
      r_acc_next <= '0;
      r_u        <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (capture_valid) begin
            r_capture  <= capture;
            r_setpoint <= setpoint;
            r_kp       <= kp;
            r_ki       <= ki;
            r_overflow <= overflow;
          end
        end
        ST_ERR: begin
          r_err <= $signed({1'b0, r_setpoint}) - $signed({1'b0, r_capture});
        end
        ST_PMUL: begin
          r_p <= w_prod;
        end
        ST_IMUL: begin
          r_acc_next <= $signed(w_acc_clamped);
          r_u        <= w_u;
        end
        ST_OUT: begin
          duty_valid <= 1'b1;
          if (r_overflow) begin
            duty  <= '0;
            r_acc <= '0;
          end else begin
            duty  <= w_duty_clamped;
            r_acc <= r_acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky overflow fault (set beats clear) and dropped-sample pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault  <= 1'b0;
      missed <= 1'b0;
    end else begin
      missed <= capture_valid && (r_state != ST_IDLE);
      if ((r_state == ST_OUT) && r_overflow) begin
        fault <= 1'b1;
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_pi_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_pi_controller
// Brief    : Self-checking bench: a transaction-level reference model checks
//            every output each cycle; directed samples pin known duty values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_pi_controller;

  localparam int SHIFT    = 6;
  localparam int DUTY_MAX = 255;
  localparam int ACC_MAX  = DUTY_MAX * (2 ** SHIFT);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] capture = '0;
  logic       capture_valid = 1'b0;
  logic       overflow = 1'b0;
  logic [8:0] setpoint = '0;
  logic [7:0] kp = '0;
  logic [7:0] ki = '0;
  logic       fault_clr = 1'b0;
  logic [7:0] duty;
  logic       duty_valid;
  logic       busy;
  logic       fault;
  logic       missed;

  int n_cmp = 0;
  int n_bad = 0;

  capture_pi_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture       (capture),
    .capture_valid (capture_valid),
    .overflow      (overflow),
    .setpoint      (setpoint),
    .kp            (kp),
    .ki            (ki),
    .fault_clr     (fault_clr),
    .duty          (duty),
    .duty_valid    (duty_valid),
    .busy          (busy),
    .fault         (fault),
    .missed        (missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one pending result with a due cycle) ----
  int cyc = 0;
  bit m_pend = 0;
  int m_due = 0;
  int m_pduty = 0;
  int m_pacc = 0;
  bit m_povf = 0;
  int m_acc = 0;
  int m_duty = 0;
  bit m_fault = 0;
  bit e_dv = 0;
  bit e_missed = 0;
  bit was_busy;
  int err, a, s, u;

  function automatic int floor_div(input int num, input int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_pend = 0; m_acc = 0; m_duty = 0; m_fault = 0; e_dv = 0; e_missed = 0;
      end else begin
        was_busy = m_pend;
        e_dv = 0;
        e_missed = 0;
        if (m_pend && m_due == cyc) begin
          m_duty = m_pduty;
          m_acc  = m_pacc;
          e_dv   = 1;
          m_pend = 0;
          if (m_povf) m_fault = 1;
          else if (fault_clr) m_fault = 0;
        end else if (fault_clr) begin
          m_fault = 0;
        end
        if (capture_valid) begin
          if (was_busy) begin
            e_missed = 1;
          end else begin
            m_pend = 1;
            m_povf = overflow;
            if (overflow) begin
              m_due = cyc + 1; m_pduty = 0; m_pacc = 0;
            end else begin
              err = int'(setpoint) - int'(capture);
              a = m_acc + err * int'(ki);
              if (a < 0) a = 0;
              if (a > ACC_MAX) a = ACC_MAX;
              s = err * int'(kp) + a;
              u = floor_div(s, 2 ** SHIFT);
              if (u < 0) u = 0;
              if (u > DUTY_MAX) u = DUTY_MAX;
              m_due = cyc + 4; m_pduty = u; m_pacc = a;
            end
          end
        end
      end
      cyc++;
      #1;
      chk("duty", int'(duty), m_duty);
      chk("duty_valid", int'(duty_valid), int'(e_dv));
      chk("busy", int'(busy), int'(m_pend));
      chk("fault", int'(fault), int'(m_fault));
      chk("missed", int'(missed), int'(e_missed));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic send(input int cap, input int sp, input int gkp, input int gki,
                      input bit ovf, input int exp_duty, input string name);
    int k;
    @(negedge clk);
    capture = 9'(cap); setpoint = 9'(sp); kp = 8'(gkp); ki = 8'(gki);
    overflow = ovf; capture_valid = 1'b1;
    @(negedge clk);
    capture_valid = 1'b0; overflow = 1'b0;
    k = 0;
    while (!duty_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!duty_valid) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_latency"}, k, ovf ? 1 : 4);
      chk(name, int'(duty), exp_duty);
    end
    repeat (2) @(negedge clk);
  endtask

  int dv_cnt;
  int dv_duty;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_dv", int'(duty_valid), 0);

    // proportional only
    send(90, 100, 64, 0, 0, 10, "p_pos");
    send(110, 100, 64, 0, 0, 0, "p_neg_clamp");

    // integral accumulation
    send(90, 100, 0, 64, 0, 10, "i_1");
    send(90, 100, 0, 64, 0, 20, "i_2");
    send(90, 100, 0, 64, 0, 30, "i_3");
    send(110, 100, 0, 64, 0, 20, "i_down");

    // reset in the middle of an update
    @(negedge clk);
    capture = 9'd90; setpoint = 9'd100; kp = 8'd0; ki = 8'd64; capture_valid = 1'b1;
    @(negedge clk);
    capture_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_busy", int'(busy), 0);
    dv_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (duty_valid) dv_cnt++;
    end
    chk("midrst_no_dv", dv_cnt, 0);
    send(90, 100, 0, 64, 0, 10, "midrst_acc0");

    // saturation and anti-windup
    for (int i = 0; i < 5; i++) send(0, 511, 255, 255, 0, 255, "sat");
    send(101, 100, 0, 64, 0, 254, "antiwindup");

    // overflow and sticky fault
    send(0, 0, 0, 0, 1, 0, "ovf");
    chk("ovf_fault", int'(fault), 1);
    send(90, 100, 0, 64, 0, 10, "post_ovf");
    chk("fault_sticky", int'(fault), 1);
    @(negedge clk); fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    chk("fault_clr", int'(fault), 0);

    // fault_clr coinciding with an overflow OUT: set wins
    @(negedge clk); overflow = 1'b1; capture_valid = 1'b1;
    @(negedge clk); overflow = 1'b0; capture_valid = 1'b0; fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    chk("set_wins", int'(fault), 1);
    @(negedge clk); fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;

    // back-to-back: second sample dropped
    send(90, 100, 0, 64, 0, 10, "b2b_pre");
    @(negedge clk);
    capture = 9'd90; setpoint = 9'd100; kp = 8'd0; ki = 8'd64; capture_valid = 1'b1;
    @(negedge clk);
    capture_valid = 1'b0;
    @(negedge clk);
    capture = 9'd0; setpoint = 9'd511; kp = 8'd255; ki = 8'd255; capture_valid = 1'b1;
    @(negedge clk);
    capture_valid = 1'b0;
    chk("b2b_missed", int'(missed), 1);
    dv_cnt = 0; dv_duty = -1;
    repeat (8) begin
      @(negedge clk);
      if (duty_valid) begin dv_cnt++; dv_duty = int'(duty); end
    end
    chk("b2b_dv_count", dv_cnt, 1);
    chk("b2b_duty", dv_duty, 20);

    // randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      capture_valid = ($urandom_range(0, 2) == 0);
      capture = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 0)
        setpoint = 9'($urandom_range(0, 511));
      else
        setpoint = 9'(((int'(capture) + $urandom_range(0, 40) + 491) % 512));
      kp = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 16));
      ki = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 16));
      overflow  = ($urandom_range(0, 15) == 0);
      fault_clr = ($urandom_range(0, 9) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    capture_valid = 1'b0; overflow = 1'b0; fault_clr = 1'b0; rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
